// File: rtl/seven_seg_scanner_if.sv
// Display-path bundle between the digit source and the seven-segment scanner.
interface seven_seg_scanner_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    load;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic [NUM_DIGITS-1:0]   blink_in;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   an;
    logic [IDX_W-1:0]        scan_idx;

    // Digit source side
    modport master (
        output load, digits_in, blank_in, blink_in,
        input  seg, an, scan_idx
    );

    // Scanner side
    modport slave (
        input  load, digits_in, blank_in, blink_in,
        output seg, an, scan_idx
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// N-digit multiplexed seven-segment driver: shadow-latched digits, one dead
// cycle per slot against ghosting, per-digit blanking and blinking.
module seven_seg_scanner #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLINK_DIV   = 25000000,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    seven_seg_scanner_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [6:0]            SEG_OFF = {7{ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{ACTIVE_LOW}};

    logic [NUM_DIGITS-1:0][3:0] digits_q;
    logic [NUM_DIGITS-1:0]      blank_q;
    logic [NUM_DIGITS-1:0]      blink_q;
    logic [CNT_W-1:0]           cnt_q;
    logic [IDX_W-1:0]           idx_q;
    logic [BLK_W-1:0]           blink_cnt_q;
    logic                       blink_phase_q;
    logic [6:0]                 seg_q;
    logic [NUM_DIGITS-1:0]      an_q;
    logic [6:0]                 seg_nxt;
    logic [NUM_DIGITS-1:0]      an_nxt;
    logic                       dark_c;

    // Active-high g..a hex decode
    function automatic logic [6:0] hex_decode(input logic [3:0] d);
        case (d)
            4'h0: hex_decode = 7'b0111111;
            4'h1: hex_decode = 7'b0000110;
            4'h2: hex_decode = 7'b1011011;
            4'h3: hex_decode = 7'b1001111;
            4'h4: hex_decode = 7'b1100110;
            4'h5: hex_decode = 7'b1101101;
            4'h6: hex_decode = 7'b1111101;
            4'h7: hex_decode = 7'b0000111;
            4'h8: hex_decode = 7'b1111111;
            4'h9: hex_decode = 7'b1101111;
            4'hA: hex_decode = 7'b1110111;
            4'hB: hex_decode = 7'b1111100;
            4'hC: hex_decode = 7'b0111001;
            4'hD: hex_decode = 7'b1011110;
            4'hE: hex_decode = 7'b1111001;
            default: hex_decode = 7'b1110001;
        endcase
    endfunction

    // Shadow registers track the inputs whenever load is high
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digits_q <= '0;
            blank_q  <= '1;
            blink_q  <= '0;
        end else if (bus.load) begin
            digits_q <= bus.digits_in;
            blank_q  <= bus.blank_in;
            blink_q  <= bus.blink_in;
        end
    end

    // Slot counter and scan index
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_q <= '0;
            idx_q <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Free-running blink timebase, independent of load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (blink_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + BLK_W'(1);
        end
    end

    // Next pin values: dark on the dead cycle or for a blanked/blinked digit
    always_comb begin
        seg_nxt = SEG_OFF;
        an_nxt  = AN_OFF;
        dark_c  = blank_q[idx_q] | (blink_q[idx_q] & blink_phase_q);
        if ((cnt_q != '0) && !dark_c) begin
            an_nxt  = NUM_DIGITS'(1) << idx_q;
            seg_nxt = hex_decode(digits_q[idx_q]);
            if (ACTIVE_LOW) begin
                an_nxt  = ~an_nxt;
                seg_nxt = ~seg_nxt;
            end
        end
    end

    // Pin registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q <= SEG_OFF;
            an_q  <= AN_OFF;
        end else begin
            seg_q <= seg_nxt;
            an_q  <= an_nxt;
        end
    end

    assign bus.seg      = seg_q;
    assign bus.an       = an_q;
    assign bus.scan_idx = idx_q;
endmodule
